// File: rtl/rv32_multicycle_core.sv
// Multi-cycle RV32I/E core: FETCH/DECODE/EXEC/MEM/WB over req/ack memories.
// Define ILLEGAL_TRAP_EN to halt in TRAP on bad encodings or register indices.
module rv32_multicycle_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NUM_REGS = 32,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata,
  output logic [31:0]       pc_o,
  output logic              retire,
  output logic              halted
);

  localparam int       RW = $clog2(NUM_REGS);
  localparam logic [5:0] NR = 6'(NUM_REGS);

  typedef enum logic [2:0] {
    FETCH, DECODE, EXEC, MEM, WB
`ifdef ILLEGAL_TRAP_EN
    , TRAP
`endif
  } state_t;

  typedef enum logic [2:0] {
    A_ADD, A_SUB, A_AND, A_OR, A_XOR, A_SLT, A_SLTU
  } alu_t;

  state_t      state, state_n;
  logic [31:0] pc, ir, a, b, imm, res, npc;
  logic [31:0] rf [NUM_REGS];

  logic [6:0] opc, f7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] f3;
  assign opc = ir[6:0];
  assign rd  = ir[11:7];
  assign f3  = ir[14:12];
  assign rs1 = ir[19:15];
  assign rs2 = ir[24:20];
  assign f7  = ir[31:25];

  function automatic logic in_rng(input logic [4:0] i);
    return {1'b0, i} < NR;
  endfunction

  function automatic logic [31:0] rd_rf(input logic [4:0] i);
    return (i != 5'd0 && in_rng(i)) ? rf[i[RW-1:0]] : 32'd0;
  endfunction

  logic legal, simm;
  logic d_wr, d_ld, d_st, d_br, d_jal, d_jalr, d_lui;
  logic wr, ld, st, br, jal, jalr, lui;
  alu_t alu_op;

  always_comb begin
    legal  = 1'b0;
    simm   = 1'b0;
    d_wr   = 1'b0;
    d_ld   = 1'b0;
    d_st   = 1'b0;
    d_br   = 1'b0;
    d_jal  = 1'b0;
    d_jalr = 1'b0;
    d_lui  = 1'b0;
    alu_op = A_ADD;
    unique case (opc)
      7'b0110011: begin
        d_wr  = 1'b1;
        legal = 1'b1;
        unique case ({f7, f3})
          10'b0000000_000: alu_op = A_ADD;
          10'b0100000_000: alu_op = A_SUB;
          10'b0000000_111: alu_op = A_AND;
          10'b0000000_110: alu_op = A_OR;
          10'b0000000_100: alu_op = A_XOR;
          10'b0000000_010: alu_op = A_SLT;
          10'b0000000_011: alu_op = A_SLTU;
          default:         legal  = 1'b0;
        endcase
      end
      7'b0010011: begin
        d_wr  = 1'b1;
        simm  = 1'b1;
        legal = 1'b1;
        unique case (f3)
          3'b000:  alu_op = A_ADD;
          3'b111:  alu_op = A_AND;
          3'b110:  alu_op = A_OR;
          3'b100:  alu_op = A_XOR;
          3'b010:  alu_op = A_SLT;
          default: legal  = 1'b0;
        endcase
      end
      7'b0000011: begin
        d_wr  = 1'b1;
        d_ld  = 1'b1;
        legal = (f3 == 3'b010);
      end
      7'b0100011: begin
        d_st  = 1'b1;
        legal = (f3 == 3'b010);
      end
      7'b0110111: begin
        d_wr  = 1'b1;
        d_lui = 1'b1;
        legal = 1'b1;
      end
      7'b1101111: begin
        d_wr  = 1'b1;
        d_jal = 1'b1;
        legal = 1'b1;
      end
      7'b1100111: begin
        d_wr   = 1'b1;
        d_jalr = 1'b1;
        legal  = (f3 == 3'b000);
      end
      7'b1100011: begin
        d_br  = 1'b1;
        legal = (f3 == 3'b000) || (f3 == 3'b001) ||
                (f3 == 3'b100) || (f3 == 3'b101);
      end
      default: ;
    endcase
  end

  // Unsupported encodings collapse to a NOP: every side effect is gated.
  assign wr   = d_wr   & legal;
  assign ld   = d_ld   & legal;
  assign st   = d_st   & legal;
  assign br   = d_br   & legal;
  assign jal  = d_jal  & legal;
  assign jalr = d_jalr & legal;
  assign lui  = d_lui  & legal;

`ifdef ILLEGAL_TRAP_EN
  logic use1, use2, bad;
  assign use1 = legal && !(lui || jal);
  assign use2 = legal && (opc == 7'b0110011 || st || br);
  assign bad  = !legal || (use1 && !in_rng(rs1)) ||
                (use2 && !in_rng(rs2)) || (wr && !in_rng(rd));
`endif

  logic [31:0] imm_n, opb, alu, agu, pc4, tgt, res_n, npc_n;
  logic        cond, taken;

  always_comb begin
    unique case (1'b1)
      st:      imm_n = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      br:      imm_n = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      lui:     imm_n = {ir[31:12], 12'd0};
      jal:     imm_n = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default: imm_n = {{20{ir[31]}}, ir[31:20]};
    endcase
  end

  always_comb begin
    opb = simm ? imm : b;
    unique case (alu_op)
      A_SUB:   alu = a - opb;
      A_AND:   alu = a & opb;
      A_OR:    alu = a | opb;
      A_XOR:   alu = a ^ opb;
      A_SLT:   alu = {31'd0, $signed(a) < $signed(opb)};
      A_SLTU:  alu = {31'd0, a < opb};
      default: alu = a + opb;
    endcase
    unique case (f3)
      3'b000:  cond = (a == b);
      3'b001:  cond = (a != b);
      3'b100:  cond = $signed(a) < $signed(b);
      3'b101:  cond = !($signed(a) < $signed(b));
      default: cond = 1'b0;
    endcase
    agu   = a + imm;
    pc4   = pc + 32'd4;
    tgt   = jalr ? agu : pc + imm;
    tgt   = {tgt[31:2], 2'b00};
    taken = jal || jalr || (br && cond);
    npc_n = taken ? tgt : pc4;
    unique case (1'b1)
      lui:         res_n = imm;
      jal || jalr: res_n = pc4;
      ld || st:    res_n = agu;
      default:     res_n = alu;
    endcase
  end

  always_comb begin
    state_n = state;
    unique case (state)
      FETCH:  if (imem_ack) state_n = DECODE;
`ifdef ILLEGAL_TRAP_EN
      DECODE: state_n = bad ? TRAP : EXEC;
      TRAP:   state_n = TRAP;
`else
      DECODE: state_n = EXEC;
`endif
      EXEC:   state_n = (ld || st) ? MEM : WB;
      MEM:    if (dmem_ack) state_n = WB;
      WB:     state_n = FETCH;
      default: state_n = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc  <= RESET_PC;
      ir  <= '0;
      a   <= '0;
      b   <= '0;
      imm <= '0;
      res <= '0;
      npc <= '0;
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    end else begin
      unique case (state)
        FETCH:  if (imem_ack) ir <= imem_rdata;
        DECODE: begin
          a   <= rd_rf(rs1);
          b   <= rd_rf(rs2);
          imm <= imm_n;
        end
        EXEC: begin
          res <= res_n;
          npc <= npc_n;
        end
        MEM: if (dmem_ack && ld) res <= dmem_rdata;
        WB: begin
          if (wr && rd != 5'd0 && in_rng(rd)) rf[rd[RW-1:0]] <= res;
          pc <= npc;
        end
        default: ;
      endcase
    end
  end

  logic mreq;
  assign mreq       = !rst && state == MEM;
  assign imem_req   = !rst && state == FETCH;
  assign imem_addr  = {pc[ADDR_W-1:2], 2'b00};
  assign dmem_req   = mreq;
  assign dmem_we    = mreq && st;
  assign dmem_addr  = mreq ? {res[ADDR_W-1:2], 2'b00} : '0;
  assign dmem_wdata = mreq ? b : '0;
  assign pc_o       = pc;
  assign retire     = !rst && state == WB;
`ifdef ILLEGAL_TRAP_EN
  assign halted     = !rst && state == TRAP;
`else
  assign halted     = 1'b0;
`endif

endmodule

// File: tb/tb_rv32_multicycle_core.sv
// Directed program bench for rv32_multicycle_core (RV32E, RESET_PC 0x100).
// Memory models give zero-wait fetch and 3-wait data with a store log.
module tb_rv32_multicycle_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [31:0] pc_o;
  logic        retire, halted;

  rv32_multicycle_core #(
    .RESET_PC(32'h100),
    .NUM_REGS(16),
    .ADDR_W  (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_rdata(imem_rdata),
    .dmem_req  (dmem_req),
    .dmem_we   (dmem_we),
    .dmem_addr (dmem_addr),
    .dmem_wdata(dmem_wdata),
    .dmem_ack  (dmem_ack),
    .dmem_rdata(dmem_rdata),
    .pc_o      (pc_o),
    .retire    (retire),
    .halted    (halted)
  );

  always #5 clk = ~clk;

`ifdef ILLEGAL_TRAP_EN
  localparam int NST = 13;
  localparam int NF  = 35;
`else
  localparam int NST = 15;
  localparam int NF  = 38;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [31:0] imem [0:127];
  logic [31:0] dmem [0:63];
  int          dcnt  = 0;
  int          dwait = 3;
  logic        dforce = 1'b0;
  logic        dblock = 1'b0;

  assign imem_ack   = imem_req;
  assign imem_rdata = imem[imem_addr[8:2]];
  assign dmem_ack   = dforce || (dmem_req && !dblock && dcnt >= dwait);
  assign dmem_rdata = dmem[dmem_addr[7:2]];

  logic [31:0] st_addr[$];
  logic [31:0] st_data[$];
  logic [31:0] f_log[$];

  always @(posedge clk) begin
    if (dmem_req && dmem_ack) begin
      dcnt <= 0;
      if (dmem_we) begin
        dmem[dmem_addr[7:2]] <= dmem_wdata;
        st_addr.push_back(dmem_addr);
        st_data.push_back(dmem_wdata);
      end
    end else if (dmem_req) dcnt <= dcnt + 1;
    else dcnt <= 0;
  end

  logic        p_wait = 1'b0;
  logic        p_we;
  logic [31:0] p_addr, p_wdata;

  always @(negedge clk) begin
    if (imem_req && imem_ack) f_log.push_back(imem_addr);
    if (rst) p_wait <= 1'b0;
    else begin
      if (dmem_req && p_wait) begin
        check("dmem_addr_hold", dmem_addr, p_addr);
        check("dmem_wdata_hold", dmem_wdata, p_wdata);
        check("dmem_we_hold", 32'(dmem_we), 32'(p_we));
      end
      p_wait  <= dmem_req && !dmem_ack;
      p_addr  <= dmem_addr;
      p_wdata <= dmem_wdata;
      p_we    <= dmem_we;
    end
  end

  function automatic logic [31:0] r_t(input logic [6:0] f7, input int rs2,
      input int rs1, input logic [2:0] f3, input int rd);
    return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'b0110011};
  endfunction

  function automatic logic [31:0] i_t(input int imm, input int rs1,
      input logic [2:0] f3, input int rd, input logic [6:0] op);
    return {12'(imm), 5'(rs1), f3, 5'(rd), op};
  endfunction

  function automatic logic [31:0] s_t(input int imm, input int rs2,
      input int rs1);
    logic [11:0] v;
    v = 12'(imm);
    return {v[11:5], 5'(rs2), 5'(rs1), 3'b010, v[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] b_t(input int imm, input int rs1,
      input int rs2, input logic [2:0] f3);
    logic [12:0] v;
    v = 13'(imm);
    return {v[12], v[10:5], 5'(rs2), 5'(rs1), f3, v[4:1], v[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] j_t(input int imm, input int rd);
    logic [20:0] v;
    v = 21'(imm);
    return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'b1101111};
  endfunction

  task automatic put(input int addr, input logic [31:0] w);
    imem[7'(addr >> 2)] = w;
  endtask

  localparam logic [6:0] OPI = 7'b0010011;

  logic [31:0] exp_sa[$];
  logic [31:0] exp_sd[$];
  logic [31:0] exp_f[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, quiet;
    for (int i = 0; i < 128; i++) imem[i] = 32'd0;
    for (int i = 0; i < 64; i++) dmem[i] = 32'd0;
    put(32'h100, i_t(5, 0, 3'b000, 1, OPI));
    put(32'h104, i_t(6, 0, 3'b000, 2, OPI));
    put(32'h108, r_t(7'h00, 1, 2, 3'b000, 3));
    put(32'h10C, s_t(0, 3, 0));
    put(32'h110, i_t(-1, 0, 3'b000, 4, OPI));
    put(32'h114, s_t(8, 4, 0));
    put(32'h118, i_t(8, 0, 3'b010, 5, 7'b0000011));
    put(32'h11C, s_t(12, 5, 0));
    put(32'h120, r_t(7'h00, 1, 4, 3'b010, 7));
    put(32'h124, r_t(7'h00, 1, 4, 3'b011, 8));
    put(32'h128, r_t(7'h20, 2, 1, 3'b000, 9));
    put(32'h12C, i_t(32'hF0, 9, 3'b100, 10, OPI));
    put(32'h130, {20'h12345, 5'd11, 7'b0110111});
    put(32'h134, r_t(7'h00, 1, 11, 3'b110, 11));
    put(32'h138, s_t(16, 7, 0));
    put(32'h13C, s_t(20, 8, 0));
    put(32'h140, s_t(24, 10, 0));
    put(32'h144, s_t(28, 11, 0));
    put(32'h148, j_t(-296, 12));
    put(32'h020, b_t(16, 1, 1, 3'b000));
    put(32'h024, i_t(1, 0, 3'b000, 13, OPI));
    put(32'h030, b_t(16, 1, 1, 3'b001));
    put(32'h034, i_t(32'h41, 0, 3'b000, 6, 7'b1100111));
    put(32'h038, i_t(2, 0, 3'b000, 13, OPI));
    put(32'h040, b_t(8, 4, 1, 3'b100));
    put(32'h044, i_t(3, 0, 3'b000, 13, OPI));
    put(32'h048, b_t(8, 4, 1, 3'b101));
    put(32'h04C, s_t(32, 12, 0));
    put(32'h050, s_t(36, 6, 0));
    put(32'h054, s_t(40, 13, 0));
    put(32'h058, i_t(32'hFF, 11, 3'b111, 14, OPI));
    put(32'h05C, s_t(44, 14, 0));
    put(32'h060, i_t(0, 4, 3'b010, 15, OPI));
    put(32'h064, r_t(7'h00, 11, 3, 3'b111, 14));
    put(32'h068, i_t(32'h700, 14, 3'b110, 14, OPI));
    put(32'h06C, s_t(48, 15, 0));
    put(32'h070, s_t(52, 14, 0));
    put(32'h074, r_t(7'h00, 1, 1, 3'b000, 17));
    put(32'h078, s_t(56, 17, 0));
    put(32'h07C, s_t(60, 1, 0));
    put(32'h080, j_t(0, 0));

    exp_sa = '{32'd0, 32'd8, 32'd12, 32'd16, 32'd20, 32'd24, 32'd28,
               32'd32, 32'd36, 32'd40, 32'd44, 32'd48, 32'd52, 32'd56,
               32'd60};
    exp_sd = '{32'h0000000B, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001,
               32'h00000000, 32'hFFFFFF0F, 32'h12345005, 32'h0000014C,
               32'h00000038, 32'h00000000, 32'h00000005, 32'h00000001,
               32'h00000701, 32'h00000000, 32'h00000005};
    for (int a = 32'h100; a <= 32'h148; a += 4) exp_f.push_back(32'(a));
    exp_f = {exp_f, 32'h20, 32'h30, 32'h34, 32'h40, 32'h48, 32'h4C,
             32'h50, 32'h54, 32'h58, 32'h5C, 32'h60, 32'h64, 32'h68,
             32'h6C, 32'h70, 32'h74, 32'h78, 32'h7C, 32'h80};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_dmem_req", 32'(dmem_req), 32'd0);
    check("rst_dmem_we", 32'(dmem_we), 32'd0);
    check("rst_retire", 32'(retire), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_dmem_addr", dmem_addr, 32'd0);
    check("rst_dmem_wdata", dmem_wdata, 32'd0);
    check("rst_pc", pc_o, 32'h100);

    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("first_req", 32'(imem_req), 32'd1);
    check("first_addr", imem_addr, 32'h100);
    check("ret_c1", 32'(retire), 32'd0);
    @(negedge clk);
    check("ret_c2", 32'(retire), 32'd0);
    @(negedge clk);
    check("ret_c3", 32'(retire), 32'd0);
    @(negedge clk);
    check("ret_c4", 32'(retire), 32'd1);
    @(negedge clk);
    check("ret_c5", 32'(retire), 32'd0);
    check("second_addr", imem_addr, 32'h104);

    for (int c = 0; c < 3000 && st_addr.size() < NST; c++) @(negedge clk);
    check("store_count", 32'(st_addr.size()), 32'(NST));
    repeat (20) @(negedge clk);
    for (int i = 0; i < NST && i < st_addr.size(); i++) begin
      check($sformatf("st_addr[%0d]", i), st_addr[i], exp_sa[i]);
      check($sformatf("st_data[%0d]", i), st_data[i], exp_sd[i]);
    end
`ifdef ILLEGAL_TRAP_EN
    check("fetch_count", 32'(f_log.size()), 32'(NF));
`else
    check("fetch_count_min", 32'(f_log.size() >= NF), 32'd1);
`endif
    for (int i = 0; i < NF && i < f_log.size(); i++)
      check($sformatf("fetch[%0d]", i), f_log[i], exp_f[i]);

`ifdef ILLEGAL_TRAP_EN
    quiet = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (imem_req || retire || dmem_req) quiet++;
    end
    check("trap_halted", 32'(halted), 32'd1);
    check("trap_pc", pc_o, 32'h74);
    check("trap_quiet", 32'(quiet), 32'd0);
    check("trap_stores", 32'(st_addr.size()), 32'(NST));
`else
    check("no_halt", 32'(halted), 32'd0);
`endif

    dblock = 1'b1;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    base = st_addr.size();
    for (int c = 0; c < 200 && !dmem_req; c++) @(negedge clk);
    check("abort_req_seen", 32'(dmem_req), 32'd1);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 begin
      rst    = 1'b1;
      dforce = 1'b1;
    end
    @(negedge clk);
    check("abort_req_low_in_rst", 32'(dmem_req), 32'd0);
    @(negedge clk);
    check("abort_dmem_req", 32'(dmem_req), 32'd0);
    check("abort_pc", pc_o, 32'h100);
    check("abort_imem_req", 32'(imem_req), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 begin
      dforce = 1'b0;
      dblock = 1'b0;
    end
    check("abort_no_store", 32'(st_addr.size()), 32'(base));
    for (int c = 0; c < 300 && st_addr.size() <= base; c++) @(negedge clk);
    check("rerun_store", 32'(st_addr.size() > base), 32'd1);
    if (st_addr.size() > base) begin
      check("rerun_addr", st_addr[base], 32'd0);
      check("rerun_data", st_data[base], 32'h0000000B);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rv32_multicycle_core.md
Name: rv32_multicycle_core

Overview:
Parametrised multi-cycle RV32 integer core. It is the next generation of the team's single-cycle processor top.
- Memories are external, reached through req/ack handshake ports, so wait states are tolerated.
- A 5-state FSM sequences each instruction.
- Adds register-file depth selection (RV32E/RV32I), branches, LUI and logical/compare ALU ops.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NUM_REGS, 32, architectural registers; 32 (RV32I) or 16 (RV32E) only.
- ADDR_W, 32, width of imem_addr/dmem_addr; PC is 32 bits internally, addresses are PC[ADDR_W-1:0].

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  ADDR_W  fetch address, word aligned.
- imem_ack  in  1  fetch complete; imem_rdata is valid this cycle.
- imem_rdata  in  32  instruction word.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store, 0 = load; valid while dmem_req is high.
- dmem_addr  out  ADDR_W  data address, bits [1:0] forced to 0.
- dmem_wdata  out  32  store data.
- dmem_ack  in  1  data access complete; dmem_rdata is valid this cycle for a load.
- dmem_rdata  in  32  load data.
- pc_o  out  32  PC of the instruction in flight.
- retire  out  1  one-cycle pulse when an instruction commits.
- halted  out  1  core stopped (trap only, see Optional Feature).

Behaviour:
Reset (clk edge with rst=1):
- State FETCH, PC=RESET_PC, all registers 0.
- imem_req, dmem_req, dmem_we, retire and halted are 0; dmem_addr and dmem_wdata are 0.
- rst mid-transaction aborts it immediately; any ack arriving during rst is ignored.

FSM states and transitions:
- FETCH: imem_req=1, imem_addr=PC. Stays until imem_ack=1; on that edge the instruction register latches imem_rdata, then go to DECODE.
- DECODE: read rs1/rs2, generate immediate (I, S, B, U, J formats, sign-extended), then go to EXEC.
- EXEC: compute ALU result, branch condition and next PC. LW/SW go to MEM; all others go to WB.
- MEM: dmem_req=1, with dmem_addr, dmem_we and dmem_wdata held stable until dmem_ack=1. A load latches dmem_rdata on the ack edge. Then go to WB.
- WB: write rd when the instruction writes a register and rd!=0. Update PC, pulse retire=1 for this one cycle, then go to FETCH.

Handshake rules:
- A request, once raised, stays high with stable address and data until ack.
- ack is sampled only while the corresponding req is high; ack on the same cycle as req is legal (zero wait).
- Minimum latency is 4 cycles per ALU, branch or jump instruction and 5 per LW/SW, plus memory wait cycles.

Supported instructions:
- ADD, SUB, AND, OR, XOR, SLT, SLTU (R-type).
- ADDI, ANDI, ORI, XORI, SLTI.
- LW, SW, LUI, JAL, JALR, BEQ, BNE, BLT, BGE.

Arithmetic and PC rules:
- All arithmetic is modulo 2^32.
- SLT/BLT/BGE compare signed; SLTU compares unsigned.
- Next PC is PC+4, or the branch/jump target. Targets always have bits [1:0] cleared (JALR clears bit 0 per ISA, bit 1 is also cleared).
- JAL/JALR write PC+4 to rd.
- PC wraps from 32'hFFFF_FFFC to 0.

Register file:
- x0 reads 0 and ignores writes.
- With NUM_REGS=16, an access to register index >=16 reads 0 and drops the write (unless ILLEGAL_TRAP_EN).
- An unsupported opcode/funct combination retires as a NOP (unless ILLEGAL_TRAP_EN).

Optional Feature:
Macro ILLEGAL_TRAP_EN.
- Defined: an unsupported encoding, or a register index >=NUM_REGS, detected in DECODE goes to state TRAP.
  - TRAP: halted=1, pc_o holds the faulting PC, no retire, no memory requests, no register writes.
  - Only rst leaves TRAP.
- Undefined: no TRAP state; halted is tied 0; the cases above behave as NOP or read-0 as described.

Test Plan:
- Reset with RESET_PC=32'h100 → first imem_addr=32'h100; all outputs 0 during rst.
- Zero-wait memory, x1=5, x2=6, ADD x3,x2,x1 → x3=11; retire pulses on cycle 4 after the fetch request.
- ADDI x4,x0,-1 then SW x4,8(x0) → dmem_req with we=1, addr=8, wdata=32'hFFFF_FFFF. Then LW x5,8(x0) with dmem_rdata=32'hFFFF_FFFF → x5=32'hFFFF_FFFF. With 3 ack wait cycles, address and data stay stable throughout.
- BEQ x1,x1,+16 at PC=0x20 → next fetch at 0x30. BNE x1,x1,+16 → next fetch at 0x24. JALR x6,x0,0x41 → fetch 0x40, x6=PC+4.
- NUM_REGS=16, ADD x17,x1,x1 → no write, retire=1 (macro off); with ILLEGAL_TRAP_EN, halted=1 and no further imem_req until rst.
- Assert rst while dmem_req is high mid-wait → next cycle dmem_req=0 and PC=RESET_PC; an ack arriving after rst is ignored.
